// File: rtl/ldpc_dvb_dec_vnode_min_sort_pkg.sv
`default_nettype none
//============================================================================
// Module      : ldpc_dvb_dec_vnode_min_sort_pkg
// Description : Shared types for the DVB-S2 LDPC decoder min-sum horizontal
//               step: vnode/cnode message types, the compressed vn_min
//               record, the saturated magnitude ceiling and a helper for
//               saturated absolute value.
// Contents    : pLLR_W, pNODE_W, pCNODE_W, pCOL_W widths
//               vnode_t, cnode_t, llr_t, vn_mag_t, vn_min_col_t, vn_min_t
//               MAXABS, VNODE_MIN, sat_abs()
// Revision    : 1.0 - initial release
//============================================================================
package ldpc_dvb_dec_vnode_min_sort_pkg;

  localparam int pLLR_W   = 4;
  localparam int pNODE_W  = 8;
  localparam int pCNODE_W = pNODE_W;
  localparam int pMAG_W   = pNODE_W - 1;
  // Column index width; comfortably covers the DVB-S2 check-node degrees.
  localparam int pCOL_W   = 5;

  typedef logic signed [pLLR_W-1:0]   llr_t;
  typedef logic signed [pNODE_W-1:0]  vnode_t;
  typedef logic signed [pCNODE_W-1:0] cnode_t;
  typedef logic        [pMAG_W-1:0]   vn_mag_t;
  typedef logic        [pCOL_W-1:0]   vn_min_col_t;

  // Packed MSB-first as {min1, min2, min1_col, prod_sign}.
  typedef struct packed {
    vn_mag_t     min1;
    vn_mag_t     min2;
    vn_min_col_t min1_col;
    logic        prod_sign;
  } vn_min_t;

  localparam vn_mag_t MAXABS    = {pMAG_W{1'b1}};
  localparam vnode_t  VNODE_MIN = {1'b1, {pMAG_W{1'b0}}};

  // |v| with the single unrepresentable magnitude (-2^(W-1)) clipped to MAXABS.
  function automatic vn_mag_t sat_abs(input vnode_t v);
    vnode_t w_neg;
    w_neg = -v;
    if (v == VNODE_MIN)
      return MAXABS;
    else if (v[pNODE_W-1])
      return w_neg[pMAG_W-1:0];
    else
      return v[pMAG_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ldpc_dvb_dec_vnode_min_sort_acc.sv
`default_nettype none
//============================================================================
// Module      : ldpc_dvb_dec_vnode_min_sort_acc
// Description : Per-row min1/min2/min1_col/prod_sign accumulator. Consumes
//               one pre-processed element (magnitude, sign, column) per
//               valid cycle and registers the finished record on eop.
// Ports       : iclk, ireset (async, active-high), iclkena (clock enable)
//               iclear      - synchronous flush of accumulator and result valid
//               ival/isop/ieop/imask - element qualifiers
//               iabs/isign/icol      - element magnitude, sign, column
//               ovn_min_val - one-cycle pulse, row result valid
//               ovn_min     - row result (holds until the next row ends)
// Revision    : 1.0 - initial release
//============================================================================
module ldpc_dvb_dec_vnode_min_sort_acc
  import ldpc_dvb_dec_vnode_min_sort_pkg::*;
(
  input  logic        iclk,
  input  logic        ireset,
  input  logic        iclkena,
  input  logic        iclear,
  input  logic        ival,
  input  logic        isop,
  input  logic        ieop,
  input  logic        imask,
  input  vn_mag_t     iabs,
  input  logic        isign,
  input  vn_min_col_t icol,
  output logic        ovn_min_val,
  output vn_min_t     ovn_min
);

  vn_min_t r_acc;
  vn_min_t r_vn_min;
  logic    r_vn_min_val;
  vn_min_t w_base;
  vn_min_t w_acc_nxt;

  // A sop element starts from {MAXABS, MAXABS, col, 0} and then runs the
  // ordinary update. This yields min1=abs/min1_col=col/prod_sign=sign for an
  // unmasked sop, and leaves the seed untouched for a masked sop. Strict '<'
  // sends ties with min1 into min2 and keeps the earliest min1_col.
  always_comb begin
    w_base    = r_acc;
    if (isop) begin
      w_base.min1      = MAXABS;
      w_base.min2      = MAXABS;
      w_base.min1_col  = icol;
      w_base.prod_sign = 1'b0;
    end
    w_acc_nxt = w_base;
    if (!imask) begin
      if (iabs < w_base.min1) begin
        w_acc_nxt.min2     = w_base.min1;
        w_acc_nxt.min1     = iabs;
        w_acc_nxt.min1_col = icol;
      end else if (iabs < w_base.min2) begin
        w_acc_nxt.min2     = iabs;
      end
      w_acc_nxt.prod_sign = w_base.prod_sign ^ isign;
    end
  end

  // The result register is loaded from the combinational next state so the
  // eop element is included without an extra cycle of latency.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_acc        <= '0;
      r_vn_min     <= '0;
      r_vn_min_val <= 1'b0;
    end else if (iclkena) begin
      if (iclear) begin
        r_acc        <= '0;
        r_vn_min_val <= 1'b0;
      end else begin
        if (ival)
          r_acc <= w_acc_nxt;
        r_vn_min_val <= ival & ieop;
        if (ival & ieop)
          r_vn_min <= w_acc_nxt;
      end
    end
  end

  assign ovn_min_val = r_vn_min_val;
  assign ovn_min     = r_vn_min;

endmodule
`default_nettype wire

// File: rtl/ldpc_dvb_dec_vnode_min_sort.sv
`default_nettype none
//============================================================================
// Module      : ldpc_dvb_dec_vnode_min_sort
// Description : Min-sum check-node compressor for the DVB-S2 LDPC decoder
//               horizontal step. Reduces the serial vnode->cnode message
//               stream of one row to {min1, min2, min1_col, prod_sign} and
//               emits a per-element sign stream for the restore stage.
// Ports       : iclk, ireset (async, active-high), iclkena (clock enable)
//               istart        - iteration start, synchronous flush
//               ival/isop/ieop - element valid, first/last of row
//               ivnode        - signed vnode message
//               ivnode_mask   - exclude element from min/sign
//               icnode_ctx    - row context, sampled with isop
//               osign_val/osign - per-element sign, 1 cycle after ival
//               ovn_min_val/ovn_min - row result, 2 cycles after eop
//               ocnode_ctx    - context of the finished row
// Revision    : 1.0 - initial release
//============================================================================
module ldpc_dvb_dec_vnode_min_sort
  import ldpc_dvb_dec_vnode_min_sort_pkg::*;
#(
  parameter int pCTX_W = 8
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              istart,
  input  logic              ival,
  input  logic              isop,
  input  logic              ieop,
  input  vnode_t            ivnode,
  input  logic              ivnode_mask,
  input  logic [pCTX_W-1:0] icnode_ctx,
  output logic              osign_val,
  output logic              osign,
  output logic              ovn_min_val,
  output vn_min_t           ovn_min,
  output logic [pCTX_W-1:0] ocnode_ctx
);

  //--------------------------------------------------------------------------
  // Stage 1: magnitude, masked sign, column index
  //--------------------------------------------------------------------------
  vn_min_col_t       r_cnt;
  logic              r_s1_val;
  logic              r_s1_sop;
  logic              r_s1_eop;
  logic              r_s1_mask;
  vn_mag_t           r_s1_abs;
  logic              r_s1_sign;
  vn_min_col_t       r_s1_col;
  logic [pCTX_W-1:0] r_s1_ctx;
  logic [pCTX_W-1:0] r_ctx_out;

  vn_min_col_t       w_col;
  vn_mag_t           w_abs;
  logic              w_sign;

  // istart flushes the counter in the same cycle, so an element arriving
  // together with istart is indexed as column 0 even without isop.
  assign w_col  = (isop | istart) ? '0 : r_cnt;
  assign w_abs  = sat_abs(ivnode);
  assign w_sign = ivnode[pNODE_W-1] & ~ivnode_mask;

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_cnt     <= '0;
      r_s1_val  <= 1'b0;
      r_s1_sop  <= 1'b0;
      r_s1_eop  <= 1'b0;
      r_s1_mask <= 1'b0;
      r_s1_abs  <= '0;
      r_s1_sign <= 1'b0;
      r_s1_col  <= '0;
      r_s1_ctx  <= '0;
    end else if (iclkena) begin
      // An element sampled with istart is the first of the new iteration,
      // so the valid simply follows ival; the stale stage-1 element is
      // dropped by the accumulator clear below.
      r_s1_val <= ival;
      if (ival) begin
        r_s1_sop  <= isop;
        r_s1_eop  <= ieop;
        r_s1_mask <= ivnode_mask;
        r_s1_abs  <= w_abs;
        r_s1_sign <= w_sign;
        r_s1_col  <= w_col;
        r_cnt     <= w_col + vn_min_col_t'(1);
        if (isop)
          r_s1_ctx <= icnode_ctx;
      end else if (istart) begin
        r_cnt <= '0;
      end
    end
  end

  assign osign_val = r_s1_val;
  assign osign     = r_s1_sign;

  //--------------------------------------------------------------------------
  // Stage 2: accumulator and row result
  //--------------------------------------------------------------------------
  ldpc_dvb_dec_vnode_min_sort_acc u_acc (
    .iclk        (iclk),
    .ireset      (ireset),
    .iclkena     (iclkena),
    .iclear      (istart),
    .ival        (r_s1_val),
    .isop        (r_s1_sop),
    .ieop        (r_s1_eop),
    .imask       (r_s1_mask),
    .iabs        (r_s1_abs),
    .isign       (r_s1_sign),
    .icol        (r_s1_col),
    .ovn_min_val (ovn_min_val),
    .ovn_min     (ovn_min)
  );

  // When a row's eop sits in stage 1 the next row's sop has not yet reached
  // stage 1, so r_s1_ctx still holds this row's context.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_ctx_out <= '0;
    end else if (iclkena) begin
      if (r_s1_val & r_s1_eop & ~istart)
        r_ctx_out <= r_s1_ctx;
    end
  end

  assign ocnode_ctx = r_ctx_out;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_dvb_dec_vnode_min_sort.sv
`default_nettype none
//============================================================================
// Module      : tb_ldpc_dvb_dec_vnode_min_sort
// Description : Directed self-checking bench for the min-sum compressor.
//               Drives hand-built rows and compares the sign stream and
//               row records against hand-computed values.
// Revision    : 1.0 - initial release
//============================================================================
module tb_ldpc_dvb_dec_vnode_min_sort;
  import ldpc_dvb_dec_vnode_min_sort_pkg::*;

  logic       iclk = 1'b0;
  logic       ireset;
  logic       iclkena;
  logic       istart;
  logic       ival;
  logic       isop;
  logic       ieop;
  vnode_t     ivnode;
  logic       ivnode_mask;
  logic [7:0] icnode_ctx;
  logic       osign_val;
  logic       osign;
  logic       ovn_min_val;
  vn_min_t    ovn_min;
  logic [7:0] ocnode_ctx;

  ldpc_dvb_dec_vnode_min_sort #(.pCTX_W(8)) dut (
    .iclk        (iclk),
    .ireset      (ireset),
    .iclkena     (iclkena),
    .istart      (istart),
    .ival        (ival),
    .isop        (isop),
    .ieop        (ieop),
    .ivnode      (ivnode),
    .ivnode_mask (ivnode_mask),
    .icnode_ctx  (icnode_ctx),
    .osign_val   (osign_val),
    .osign       (osign),
    .ovn_min_val (ovn_min_val),
    .ovn_min     (ovn_min),
    .ocnode_ctx  (ocnode_ctx)
  );

  always #5 iclk = ~iclk;

  // Enabled-edge counter; latency is measured in enabled cycles.
  int   ecyc = 0;
  logic en_at_edge = 1'b0;
  always @(posedge iclk) begin
    en_at_edge = iclkena & ~ireset;
    if (iclkena && !ireset) ecyc++;
  end

  typedef struct {
    vn_min_t    r;
    logic [7:0] ctx;
    int         cyc;
  } res_t;
  res_t res_q[$];
  logic sign_q[$];

  // Outputs are only captured once per enabled edge, mid-cycle.
  always @(negedge iclk) begin
    res_t e;
    if (en_at_edge) begin
      if (ovn_min_val) begin
        e.r   = ovn_min;
        e.ctx = ocnode_ctx;
        e.cyc = ecyc;
        res_q.push_back(e);
      end
      if (osign_val) sign_q.push_back(osign);
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  bit gate_mode = 1'b0;
  int last_edge = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance until one enabled edge has sampled the current inputs.
  task automatic step();
    bit hit;
    int tries;
    hit   = 1'b0;
    tries = 0;
    do begin
      @(posedge iclk);
      #1;
      hit = en_at_edge;
      if (gate_mode) iclkena = ~iclkena;
      tries++;
    end while (!hit && tries < 8);
    if (!hit) chk("step_timeout", 32'd0, 32'd1);
    last_edge = ecyc;
  endtask

  task automatic elem(input logic sop, input logic eop, input logic mask,
                      input int v, input logic [7:0] ctx);
    ival        = 1'b1;
    isop        = sop;
    ieop        = eop;
    ivnode_mask = mask;
    ivnode      = vnode_t'(v);
    icnode_ctx  = ctx;
    step();
    ival        = 1'b0;
    isop        = 1'b0;
    ieop        = 1'b0;
    ivnode_mask = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clr_q();
    res_q.delete();
    sign_q.delete();
  endtask

  task automatic chk_res(input string tag, input int m1, input int m2,
                         input int col, input int ps, input int ctx, input int eop_edge);
    res_t e;
    if (res_q.size() == 0) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      e = res_q.pop_front();
      chk({tag, "_min1"}, 32'(e.r.min1), 32'(m1));
      chk({tag, "_min2"}, 32'(e.r.min2), 32'(m2));
      chk({tag, "_col"},  32'(e.r.min1_col), 32'(col));
      chk({tag, "_sign"}, 32'(e.r.prod_sign), 32'(ps));
      chk({tag, "_ctx"},  32'(e.ctx), 32'(ctx));
      chk({tag, "_lat"},  32'(e.cyc), 32'(eop_edge + 1));
    end
  endtask

  task automatic chk_signs(input string tag, input logic [7:0] bits, input int n);
    chk({tag, "_nsign"}, 32'(sign_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (sign_q.size() > 0) chk({tag, "_osign"}, 32'(sign_q.pop_front()), 32'(bits[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1, e2;
    ireset = 1'b1; iclkena = 1'b1; istart = 1'b0; ival = 1'b0;
    isop = 1'b0; ieop = 1'b0; ivnode = '0; ivnode_mask = 1'b0; icnode_ctx = '0;
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_vn_min_val", 32'(ovn_min_val), 32'd0);
    chk("rst_vn_min",     32'(ovn_min), 32'd0);
    chk("rst_sign_val",   32'(osign_val), 32'd0);
    chk("rst_ctx",        32'(ocnode_ctx), 32'd0);
    ireset = 1'b0;
    idle(2);

    // Row +5,-3,+7,-3
    clr_q();
    elem(1, 0, 0,  5, 8'h11);
    elem(0, 0, 0, -3, 8'h00);
    elem(0, 0, 0,  7, 8'h00);
    elem(0, 1, 0, -3, 8'h00);
    e1 = last_edge;
    idle(4);
    chk_signs("rowA", 8'b1010, 4);
    chk_res("rowA", 3, 3, 1, 0, 8'h11, e1);
    chk("rowA_extra", 32'(res_q.size()), 32'd0);

    // Row -128,+10
    clr_q();
    elem(1, 0, 0, -128, 8'h22);
    elem(0, 1, 0,   10, 8'h00);
    e1 = last_edge;
    idle(4);
    chk_res("rowB", 10, 127, 1, 1, 8'h22, e1);

    // Single-element row -128
    clr_q();
    elem(1, 1, 0, -128, 8'h23);
    e1 = last_edge;
    idle(4);
    chk_res("single", 127, 127, 0, 1, 8'h23, e1);

    // Masked elements
    clr_q();
    elem(1, 0, 1,  4, 8'h24);
    elem(0, 0, 0, -2, 8'h00);
    elem(0, 1, 1,  9, 8'h00);
    e1 = last_edge;
    idle(4);
    chk_signs("mask", 8'b010, 3);
    chk_res("mask", 2, 127, 1, 1, 8'h24, e1);

    // Fully masked two-element row
    clr_q();
    elem(1, 0, 1, -5, 8'h25);
    elem(0, 1, 1, -6, 8'h00);
    e1 = last_edge;
    idle(4);
    chk_signs("allmask", 8'b00, 2);
    chk_res("allmask", 127, 127, 0, 0, 8'h25, e1);

    // Back-to-back rows, no gap
    clr_q();
    elem(1, 0, 0,  6, 8'h33);
    elem(0, 0, 0,  2, 8'h00);
    elem(0, 1, 0, -9, 8'h00);
    e1 = last_edge;
    elem(1, 0, 0, -1, 8'h44);
    elem(0, 0, 0, -1, 8'h00);
    elem(0, 1, 0,  1, 8'h00);
    e2 = last_edge;
    idle(4);
    chk("b2b_count", 32'(res_q.size()), 32'd2);
    chk("b2b_gap", 32'(e2 - e1), 32'd3);
    chk_res("b2b_rowC", 2, 6, 1, 1, 8'h33, e1);
    chk_res("b2b_rowD", 1, 1, 0, 0, 8'h44, e2);

    // Clock enable toggling every cycle during the row
    clr_q();
    gate_mode = 1'b1;
    elem(1, 0, 0,  5, 8'h55);
    elem(0, 0, 0, -3, 8'h00);
    elem(0, 0, 0,  7, 8'h00);
    elem(0, 1, 0, -3, 8'h00);
    e1 = last_edge;
    idle(4);
    gate_mode = 1'b0;
    iclkena   = 1'b1;
    idle(2);
    chk_signs("gated", 8'b1010, 4);
    chk_res("gated", 3, 3, 1, 0, 8'h55, e1);
    chk("gated_extra", 32'(res_q.size()), 32'd0);

    // istart mid-row; the new row's first element arrives with istart
    clr_q();
    elem(1, 0, 0, 1, 8'h66);
    elem(0, 0, 0, 1, 8'h00);
    istart = 1'b1;
    elem(1, 0, 0, -20, 8'h77);
    istart = 1'b0;
    elem(0, 1, 0, 30, 8'h00);
    e1 = last_edge;
    idle(4);
    chk("start_count", 32'(res_q.size()), 32'd1);
    chk_res("start", 20, 30, 0, 1, 8'h77, e1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
